apb_master_bridge: RTL and testbench
====================================

Name: apb_master_bridge

Overview:
- Initiator end of the APB fabric: converts a simple core-side req/gnt/rvalid transaction port into APB SETUP/ACCESS transfers.
- Drives the single upstream port of the APB node: penable, pwrite, paddr, pwdata, plus a single psel.
- Handles wait states and slave errors, and has a watchdog that terminates hung transfers with an error response.
- Synchronous to the peripheral clock, one outstanding transfer at a time.

Parameters:
- APB_ADDR_WIDTH, 32, width of addr_i/paddr_o.
- APB_DATA_WIDTH, 32, width of all data buses.
- TIMEOUT_CYCLES, 255, max ACCESS cycles with pready_i low before abort; 0 disables the watchdog.
- TO_CNT_WIDTH, 8, watchdog counter width; must hold TIMEOUT_CYCLES.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- req_i  in  1  core request valid.
- we_i  in  1  1 = write, 0 = read.
- addr_i  in  APB_ADDR_WIDTH  request address.
- wdata_i  in  APB_DATA_WIDTH  write data.
- gnt_o  out  1  request accepted this cycle (combinational).
- rvalid_o  out  1  one-cycle response strobe.
- rdata_o  out  APB_DATA_WIDTH  read data; 0 for writes and errors.
- err_o  out  1  response error; valid with rvalid_o.
- psel_o  out  1  APB select.
- penable_o  out  1  APB enable.
- pwrite_o  out  1  APB direction.
- paddr_o  out  APB_ADDR_WIDTH  APB address.
- pwdata_o  out  APB_DATA_WIDTH  APB write data.
- prdata_i  in  APB_DATA_WIDTH  APB read data.
- pready_i  in  1  APB ready.
- pslverr_i  in  1  APB slave error.

Behaviour:
- Clock and reset: one clock, clk_i. rst_ni is asynchronous, active-low.
- Reset:
  - State goes to IDLE.
  - psel_o, penable_o, pwrite_o, rvalid_o and err_o are 0.
  - paddr_o, pwdata_o and rdata_o are 0.
  - Watchdog counter is 0.
  - Reset asserted mid-transfer drops psel_o/penable_o immediately and discards the transfer; no response is issued.
- States: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - psel_o=0, penable_o=0.
  - gnt_o = req_i.
  - On req_i, register addr_i/we_i/wdata_i into paddr_o/pwrite_o/pwdata_o and go to SETUP.
- SETUP (exactly 1 cycle):
  - psel_o=1, penable_o=0.
  - Watchdog cleared.
  - Next state is ACCESS.
- ACCESS:
  - psel_o=1, penable_o=1.
  - paddr/pwrite/pwdata held stable.
  - If pready_i=1: capture rdata = (pwrite_o|pslverr_i) ? 0 : prdata_i, capture err = pslverr_i, go to RESP.
  - Else if TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1: abort with rdata=0, err=1, go to RESP.
  - Else the counter increments.
  - pready_i has priority over timeout in the same cycle.
- RESP:
  - rvalid_o=1 for exactly this cycle, with rdata_o/err_o valid; psel_o=0, penable_o=0.
  - gnt_o = req_i. If req_i, latch the new request and go to SETUP, else go to IDLE.
  - Back-to-back throughput is one transfer per 3 cycles when pready_i is tied high.
- Response latency: a zero-wait-state transfer has grant in cycle 0, SETUP in cycle 1, ACCESS in cycle 2, rvalid_o in cycle 3.
- Output hold: paddr_o/pwrite_o/pwdata_o hold their last value when idle (not re-zeroed). rdata_o/err_o hold until the next response.
- gnt_o is never asserted in SETUP or ACCESS; a held req_i waits.
- Outputs psel_o/penable_o/paddr_o/pwrite_o/pwdata_o/rvalid_o/rdata_o/err_o are registered; gnt_o is combinational from state and req_i.

Decomposition:
- apb_pkg holds:
  - the apb_mst_state_e enum (IDLE/SETUP/ACCESS/RESP);
  - default APB_ADDR_WIDTH/APB_DATA_WIDTH constants;
  - TIMEOUT_DEFAULT.
- Single module; the watchdog is an inline counter with no separate sub-module.

Test Plan:
- Read, pready_i=1, addr_i=32'h1A10_0008, prdata_i=32'hDEAD_BEEF -> psel_o rises at cycle 1, penable_o at cycle 2, rvalid_o at cycle 3 with rdata_o=32'hDEAD_BEEF, err_o=0.
- Write addr_i=32'h1A10_1000, wdata_i=32'h0000_00A5, pready_i low 3 ACCESS cycles -> paddr_o/pwdata_o/pwrite_o=1 stable across all 4 ACCESS cycles; rvalid_o 1 cycle after pready_i with rdata_o=0, err_o=0.
- Read with pslverr_i=1 on the ready cycle, prdata_i=32'h1234_5678 -> rvalid_o=1, err_o=1, rdata_o=0.
- TIMEOUT_CYCLES=4, pready_i stuck 0 -> exactly 4 ACCESS cycles, then psel_o=0 and rvalid_o=1, err_o=1; a pready_i=1 arriving in the 4th cycle yields err_o=pslverr_i instead.
- req_i held high for 3 reads with pready_i=1 -> gnt_o pulses in cycles 0, 3 and 6; rvalid_o in cycles 3, 6 and 9; psel_o low in every RESP cycle.
- rst_ni driven low asynchronously mid-ACCESS -> psel_o/penable_o fall before the next clock edge; no rvalid_o after release; next req_i is granted from IDLE.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types and defaults for the APB initiator bridge.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_mst_state_e;

  localparam int unsigned APB_ADDR_WIDTH_DEFAULT = 32;
  localparam int unsigned APB_DATA_WIDTH_DEFAULT = 32;
  localparam int unsigned TIMEOUT_DEFAULT        = 255;

endpackage

// File: rtl/apb_master_bridge.sv
// Core req/gnt/rvalid port to APB initiator: one outstanding transfer, wait
// states, slave errors and a watchdog that turns a hung ACCESS into an error.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int unsigned APB_ADDR_WIDTH = APB_ADDR_WIDTH_DEFAULT,
  parameter int unsigned APB_DATA_WIDTH = APB_DATA_WIDTH_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
  parameter int unsigned TO_CNT_WIDTH   = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      req_i,
  input  logic                      we_i,
  input  logic [APB_ADDR_WIDTH-1:0] addr_i,
  input  logic [APB_DATA_WIDTH-1:0] wdata_i,
  output logic                      gnt_o,
  output logic                      rvalid_o,
  output logic [APB_DATA_WIDTH-1:0] rdata_o,
  output logic                      err_o,
  output logic                      psel_o,
  output logic                      penable_o,
  output logic                      pwrite_o,
  output logic [APB_ADDR_WIDTH-1:0] paddr_o,
  output logic [APB_DATA_WIDTH-1:0] pwdata_o,
  input  logic [APB_DATA_WIDTH-1:0] prdata_i,
  input  logic                      pready_i,
  input  logic                      pslverr_i
);

  apb_mst_state_e          state_q, state_d;
  logic [TO_CNT_WIDTH-1:0] to_cnt_q;
  logic                    timeout_hit;

  assign timeout_hit = (TIMEOUT_CYCLES != 0) &&
                       (to_cnt_q == TO_CNT_WIDTH'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d = state_q;
    gnt_o   = 1'b0;
    case (state_q)
      IDLE: begin
        gnt_o = req_i;
        if (req_i) state_d = SETUP;
      end
      SETUP:  state_d = ACCESS;
      ACCESS: if (pready_i || timeout_hit) state_d = RESP;
      RESP: begin
        gnt_o   = req_i;
        state_d = req_i ? SETUP : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // APB strobes and the response strobe are registered from the next state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      psel_o    <= 1'b0;
      penable_o <= 1'b0;
      rvalid_o  <= 1'b0;
      pwrite_o  <= 1'b0;
      paddr_o   <= '0;
      pwdata_o  <= '0;
      rdata_o   <= '0;
      err_o     <= 1'b0;
      to_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      psel_o    <= (state_d == SETUP) || (state_d == ACCESS);
      penable_o <= (state_d == ACCESS);
      rvalid_o  <= (state_d == RESP);

      if (gnt_o) begin
        paddr_o  <= addr_i;
        pwrite_o <= we_i;
        pwdata_o <= wdata_i;
      end

      // pready wins over the watchdog when both land in the same cycle
      if (state_q == ACCESS) begin
        if (pready_i) begin
          rdata_o <= (pwrite_o || pslverr_i) ? '0 : prdata_i;
          err_o   <= pslverr_i;
        end else if (timeout_hit) begin
          rdata_o <= '0;
          err_o   <= 1'b1;
        end
      end

      if (state_q == SETUP) begin
        to_cnt_q <= '0;
      end else if ((state_q == ACCESS) && !pready_i && !timeout_hit) begin
        to_cnt_q <= to_cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: directed table, multi-cycle
// corner sequences and randomized transfers against a transaction-level model.
module tb_apb_master_bridge;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, we, pready, pslverr;
  logic [31:0] addr, wdata, prdata;
  logic        gnt, rvalid, err, psel, penable, pwrite;
  logic [31:0] rdata, paddr, pwdata;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int gnt_cyc[$];

  apb_master_bridge #(
    .APB_ADDR_WIDTH(32),
    .APB_DATA_WIDTH(32),
    .TIMEOUT_CYCLES(TO),
    .TO_CNT_WIDTH  (8)
  ) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .req_i    (req),
    .we_i     (we),
    .addr_i   (addr),
    .wdata_i  (wdata),
    .gnt_o    (gnt),
    .rvalid_o (rvalid),
    .rdata_o  (rdata),
    .err_o    (err),
    .psel_o   (psel),
    .penable_o(penable),
    .pwrite_o (pwrite),
    .paddr_o  (paddr),
    .pwdata_o (pwdata),
    .prdata_i (prdata),
    .pready_i (pready),
    .pslverr_i(pslverr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] prd;
    int          w;        // pready low cycles before ready; >= TO means stuck
    logic        slverr;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_acc;  // ACCESS cycles expected
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Transaction-level reference: response content and ACCESS length
  function automatic void model(input logic m_we, input int m_w, input logic m_se,
                                input logic [31:0] m_prd, output logic e_err,
                                output logic [31:0] e_rd, output int e_acc);
    if (m_w >= TO) begin
      e_err = 1'b1; e_rd = 32'h0; e_acc = TO;
    end else begin
      e_err = m_se; e_rd = (m_we || m_se) ? 32'h0 : m_prd; e_acc = m_w + 1;
    end
  endfunction

  // Starts in an IDLE or RESP cycle, ends in the RESP cycle of this transfer.
  task automatic txn(input vec_t v, input bit hold);
    req = 1'b1; we = v.we; addr = v.addr; wdata = v.wdata;
    pready = 1'b0; pslverr = 1'($urandom); prdata = $urandom;
    #1;
    chk("gnt_on_req", {31'b0, gnt}, 32'd1);
    gnt_cyc.push_back(cyc);
    step();
    if (!hold) req = 1'b0;
    addr = $urandom; wdata = $urandom; we = 1'($urandom);
    #1;
    chk("setup_psel",    {31'b0, psel},    32'd1);
    chk("setup_penable", {31'b0, penable}, 32'd0);
    chk("setup_gnt",     {31'b0, gnt},     32'd0);
    chk("setup_paddr",   paddr,            v.addr);
    chk("setup_pwrite",  {31'b0, pwrite},  {31'b0, v.we});
    step();
    for (int i = 0; i < v.exp_acc; i++) begin
      pready  = (i == v.w);
      pslverr = pready ? v.slverr : 1'($urandom);
      prdata  = pready ? v.prd : $urandom;
      #1;
      chk("acc_psel",    {31'b0, psel},    32'd1);
      chk("acc_penable", {31'b0, penable}, 32'd1);
      chk("acc_gnt",     {31'b0, gnt},     32'd0);
      chk("acc_rvalid",  {31'b0, rvalid},  32'd0);
      chk("acc_paddr",   paddr,            v.addr);
      chk("acc_pwdata",  pwdata,           v.wdata);
      chk("acc_pwrite",  {31'b0, pwrite},  {31'b0, v.we});
      step();
    end
    pready = 1'b0; pslverr = 1'b0;
    #1;
    chk("resp_rvalid",  {31'b0, rvalid},  32'd1);
    chk("resp_err",     {31'b0, err},     {31'b0, v.exp_err});
    chk("resp_rdata",   rdata,            v.exp_rdata);
    chk("resp_psel",    {31'b0, psel},    32'd0);
    chk("resp_penable", {31'b0, penable}, 32'd0);
  endtask

  // From a RESP cycle into IDLE; response fields must hold.
  task automatic idle(input logic h_err, input logic [31:0] h_rd);
    req = 1'b0; pready = 1'b0;
    step();
    chk("idle_rvalid", {31'b0, rvalid}, 32'd0);
    chk("idle_psel",   {31'b0, psel},   32'd0);
    chk("idle_rdata",  rdata,           h_rd);
    chk("idle_err",    {31'b0, err},    {31'b0, h_err});
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[7];
    vec_t v;

    tbl[0] = '{1'b0, 32'h1A10_0008, 32'h0,          32'hDEAD_BEEF, 0,  1'b0, 1'b0, 32'hDEAD_BEEF, 1};
    tbl[1] = '{1'b1, 32'h1A10_1000, 32'h0000_00A5, 32'h1111_1111, 3,  1'b0, 1'b0, 32'h0,         4};
    tbl[2] = '{1'b0, 32'h1A10_2004, 32'h0,          32'h1234_5678, 0,  1'b1, 1'b1, 32'h0,         1};
    tbl[3] = '{1'b0, 32'h1A10_3000, 32'h0,          32'h0000_0055, 99, 1'b0, 1'b1, 32'h0,         4};
    tbl[4] = '{1'b0, 32'h1A10_3004, 32'h0,          32'h0000_00AA, 3,  1'b1, 1'b1, 32'h0,         4};
    tbl[5] = '{1'b0, 32'h1A10_3008, 32'h0,          32'hCAFE_F00D, 3,  1'b0, 1'b0, 32'hCAFE_F00D, 4};
    tbl[6] = '{1'b1, 32'h1A10_400C, 32'h7777_0000, 32'h9999_9999, 1,  1'b1, 1'b1, 32'h0,         2};

    rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    prdata = '0; pready = 1'b0; pslverr = 1'b0;
    step(); step();
    chk("rst_psel",    {31'b0, psel},    32'd0);
    chk("rst_penable", {31'b0, penable}, 32'd0);
    chk("rst_rvalid",  {31'b0, rvalid},  32'd0);
    chk("rst_err",     {31'b0, err},     32'd0);
    chk("rst_pwrite",  {31'b0, pwrite},  32'd0);
    chk("rst_paddr",   paddr,            32'd0);
    chk("rst_pwdata",  pwdata,           32'd0);
    chk("rst_rdata",   rdata,            32'd0);
    chk("rst_gnt",     {31'b0, gnt},     32'd0);
    #2 rst_n = 1'b1;
    step();

    for (int i = 0; i < 7; i++) begin
      txn(tbl[i], 1'b0);
      idle(tbl[i].exp_err, tbl[i].exp_rdata);
      chk("idle_paddr_hold", paddr, tbl[i].addr);
    end

    // Held req_i: three zero-wait reads, grants every third cycle
    gnt_cyc.delete();
    for (int i = 0; i < 3; i++) begin
      v = '{1'b0, 32'h2000_0000 + 32'(i * 4), 32'h0, 32'hA000_0000 + 32'(i), 0, 1'b0,
            1'b0, 32'hA000_0000 + 32'(i), 1};
      txn(v, 1'b1);
    end
    idle(1'b0, 32'hA000_0002);
    chk("b2b_gnt_gap1", 32'(gnt_cyc[1] - gnt_cyc[0]), 32'd3);
    chk("b2b_gnt_gap2", 32'(gnt_cyc[2] - gnt_cyc[1]), 32'd3);

    // Asynchronous reset in the middle of ACCESS
    req = 1'b1; we = 1'b0; addr = 32'h3000_0010; pready = 1'b0;
    step();
    req = 1'b0;
    step();
    chk("pre_rst_penable", {31'b0, penable}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_psel",    {31'b0, psel},    32'd0);
    chk("async_rst_penable", {31'b0, penable}, 32'd0);
    step();
    #2 rst_n = 1'b1;
    pready = 1'b1; prdata = 32'hBAD0_BAD0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_rst_rvalid", {31'b0, rvalid}, 32'd0);
      chk("post_rst_psel",   {31'b0, psel},   32'd0);
    end
    pready = 1'b0;
    v = '{1'b0, 32'h3000_0020, 32'h0, 32'h0BAD_F00D, 1, 1'b0, 1'b0, 32'h0BAD_F00D, 2};
    txn(v, 1'b0);
    idle(1'b0, 32'h0BAD_F00D);

    // Randomized transfers against the transaction model
    for (int n = 0; n < 40; n++) begin
      v.we     = 1'($urandom);
      v.addr   = $urandom;
      v.wdata  = $urandom;
      v.prd    = $urandom;
      v.w      = int'($urandom_range(0, 5));
      v.slverr = ($urandom_range(0, 3) == 0);
      model(v.we, v.w, v.slverr, v.prd, v.exp_err, v.exp_rdata, v.exp_acc);
      txn(v, 1'b0);
      if ($urandom_range(0, 1) == 1) idle(v.exp_err, v.exp_rdata);
    end
    idle(v.exp_err, v.exp_rdata);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
